// File: rtl/debounce_botoes_pkg.sv
// Shared constants and helpers for the alarm push-button conditioning stage.
// Channel count and the debounce counter width rule live here.
package debounce_botoes_pkg;

   localparam int NUM_BTN = 3;

   // Wide enough to hold DEBOUNCE_CYCLES; the counter is cleared before it could wrap.
   function automatic int cnt_width(input int debounce_cycles);
      return $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_canal.sv
// One button channel: synchroniser chain, polarity fix, stability counter,
// debounced level and one-cycle press/release pulses.
module debounce_canal
   import debounce_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES     = 2,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic          IDLE_PAD = (ACTIVE_LOW != 0);
   localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   s;

   // Chain resets to the idle pad value so reset release never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{IDLE_PAD}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1] ^ IDLE_PAD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         if (s == level) begin
            cnt <= '0;
         end else if (cnt == TERMINAL) begin
            // Input held long enough: flip level and emit the matching pulse.
            level         <= s;
            cnt           <= '0;
            press_pulse   <= s;
            release_pulse <= ~s;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/debounce_botoes.sv
// Input conditioning for the three alarm buttons: one independent debounce
// channel per pad, outputs feed the majority alarm inputs A/B/C.
module debounce_botoes
   import debounce_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES     = 2,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] btn_raw,
   output logic [2:0] btn_level,
   output logic [2:0] btn_press,
   output logic [2:0] btn_release
);

   param_ok: assert property (@(posedge clk) (DEBOUNCE_CYCLES >= 1) && (SYNC_STAGES >= 2))
      else $error("debounce_botoes: DEBOUNCE_CYCLES must be >=1 and SYNC_STAGES >=2");

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_canal
      debounce_canal #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_canal (
         .clk           (clk),
         .rst           (rst),
         .raw_in        (btn_raw[i]),
         .level         (btn_level[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i])
      );
   end

endmodule

// File: tb/tb_debounce_botoes.sv
// Bench for debounce_botoes: directed scenarios with fixed timing expectations plus
// randomized pad activity checked against a timestamp-based reference model.
module tb_debounce_botoes;

   localparam int DEB  = 8;
   localparam int SYNC = 2;
   localparam int ALOW = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] btn_raw = 3'b111;
   logic [2:0] btn_level, btn_press, btn_release;

   int n_tests  = 0;
   int n_failed = 0;

   debounce_botoes #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYNC),
      .ACTIVE_LOW      (ALOW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   always #5 clk = ~clk;

   // Reference model: level flips once the synced input has disagreed with it for
   // DEB consecutive edges, measured from the last edge at which they agreed.
   logic [2:0] hist[$];
   logic [2:0] m_level, m_press, m_release;
   int         edge_n;
   int         last_agree[3];

   task automatic model_reset();
      hist = {};
      for (int i = 0; i < SYNC; i++) hist.push_back(ALOW ? 3'b111 : 3'b000);
      m_level   = 3'b000;
      m_press   = 3'b000;
      m_release = 3'b000;
      for (int i = 0; i < 3; i++) last_agree[i] = edge_n;
   endtask

   task automatic model_edge(input logic [2:0] raw);
      logic [2:0] oldest, s;
      oldest = hist.pop_front();
      s = ALOW ? ~oldest : oldest;
      hist.push_back(raw);
      edge_n++;
      m_press   = 3'b000;
      m_release = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (s[i] == m_level[i]) begin
            last_agree[i] = edge_n;
         end else if (edge_n - last_agree[i] >= DEB) begin
            m_level[i] = s[i];
            if (s[i]) m_press[i] = 1'b1;
            else      m_release[i] = 1'b1;
            last_agree[i] = edge_n;
         end
      end
   endtask

   // Drive one clock of input, advance the model on the edge, sample 1 time unit later.
   task automatic tick(input logic [2:0] raw);
      btn_raw = raw;
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge(raw);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         btn_raw = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
         n_tests++;
         if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            n_failed++;
            $display("FAIL reset k=%0d got lvl=%b prs=%b rel=%b exp all 0", k, btn_level, btn_press, btn_release);
         end
      end
      btn_raw = 3'b111;
      edge_n = 0;
      model_reset();
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick(3'b111);
         n_tests++;
         if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            n_failed++;
            $display("FAIL reset_idle k=%0d got lvl=%b prs=%b rel=%b exp all 0", k, btn_level, btn_press, btn_release);
         end
      end
   endtask

   task automatic test_single_press();
      logic [2:0] el, ep;
      for (int k = 1; k <= 20; k++) begin
         tick(3'b110);
         el = (k >= 10) ? 3'b001 : 3'b000;
         ep = (k == 10) ? 3'b001 : 3'b000;
         n_tests++;
         if (btn_level !== el || btn_press !== ep || btn_release !== 3'b000) begin
            n_failed++;
            $display("FAIL single_press k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=000", k, btn_level, btn_press, btn_release, el, ep);
         end
      end
      for (int k = 1; k <= 14; k++) begin
         tick(3'b111);
         n_tests++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            n_failed++;
            $display("FAIL single_release k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k, btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
      end
   endtask

   task automatic test_bounce();
      logic [2:0] el, ep;
      for (int k = 0; k < 30; k++) begin
         tick(((k / 3) % 2 == 0) ? 3'b101 : 3'b111);
         n_tests++;
         if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            n_failed++;
            $display("FAIL bounce k=%0d got lvl=%b prs=%b rel=%b exp all 0", k, btn_level, btn_press, btn_release);
         end
      end
      for (int k = 1; k <= 14; k++) begin
         tick(3'b101);
         el = (k >= 10) ? 3'b010 : 3'b000;
         ep = (k == 10) ? 3'b010 : 3'b000;
         n_tests++;
         if (btn_level !== el || btn_press !== ep || btn_release !== 3'b000) begin
            n_failed++;
            $display("FAIL bounce_settle k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=000", k, btn_level, btn_press, btn_release, el, ep);
         end
      end
      for (int k = 0; k < 14; k++) tick(3'b111);
      n_tests++;
      if (btn_level !== 3'b000 || btn_level !== m_level) begin
         n_failed++;
         $display("FAIL bounce_idle got lvl=%b exp 000", btn_level);
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 22; k++) begin
         tick((k < 7) ? 3'b011 : 3'b111);
         n_tests++;
         if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            n_failed++;
            $display("FAIL glitch k=%0d got lvl=%b prs=%b rel=%b exp all 0", k, btn_level, btn_press, btn_release);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] el, ep, er;
      for (int k = 1; k <= 45; k++) begin
         tick((k <= 30) ? 3'b100 : 3'b111);
         el = (k >= 10 && k < 40) ? 3'b011 : 3'b000;
         ep = (k == 10) ? 3'b011 : 3'b000;
         er = (k == 40) ? 3'b011 : 3'b000;
         n_tests++;
         if (btn_level !== el || btn_press !== ep || btn_release !== er) begin
            n_failed++;
            $display("FAIL simultaneous k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k, btn_level, btn_press, btn_release, el, ep, er);
         end
      end
   endtask

   task automatic test_reset_held();
      logic [2:0] el, ep;
      for (int k = 0; k < 12; k++) tick(3'b110);
      n_tests++;
      if (btn_level !== 3'b001) begin
         n_failed++;
         $display("FAIL held_pre_reset got lvl=%b exp 001", btn_level);
      end
      // Asynchronous assert with the level high must clear outputs without a clock edge.
      rst = 1'b1;
      #1;
      model_reset();
      n_tests++;
      if (btn_level !== 3'b000) begin
         n_failed++;
         $display("FAIL async_reset got lvl=%b exp 000", btn_level);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 7; k++) tick(3'b110);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(3'b110);
         n_tests++;
         if ({btn_level, btn_press, btn_release} !== 9'b0) begin
            n_failed++;
            $display("FAIL reset_mid_count k=%0d got lvl=%b prs=%b rel=%b exp all 0", k, btn_level, btn_press, btn_release);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick(3'b110);
         el = (k >= 10) ? 3'b001 : 3'b000;
         ep = (k == 10) ? 3'b001 : 3'b000;
         n_tests++;
         if (btn_level !== el || btn_press !== ep || btn_release !== 3'b000) begin
            n_failed++;
            $display("FAIL reset_held k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=000", k, btn_level, btn_press, btn_release, el, ep);
         end
      end
      for (int k = 0; k < 14; k++) tick(3'b111);
   endtask

   task automatic test_random();
      logic [2:0] raw;
      int         hold[3];
      raw = 3'b111;
      for (int i = 0; i < 3; i++) hold[i] = 0;
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (hold[i] == 0) begin
               raw[i]  = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 14);
            end
            hold[i]--;
         end
         rst = ($urandom_range(0, 149) == 0);
         tick(raw);
         rst = 1'b0;
         n_tests++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            n_failed++;
            $display("FAIL random k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=%b", k, btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
         n_tests++;
         if ((btn_press & btn_release) !== 3'b000) begin
            n_failed++;
            $display("FAIL random_excl k=%0d got prs=%b rel=%b exp disjoint", k, btn_press, btn_release);
         end
      end
   endtask

   initial begin
      edge_n = 0;
      model_reset();
      test_reset();
      test_single_press();
      test_bounce();
      test_glitch();
      test_back_to_back();
      test_reset_held();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
